store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter NUM_ENTRIES, default STB_NUM_ENTRIES (4), number of buffered stores; power of two, at least 2.
REQ-002 clk  in  1  clock; one clock domain, all state updates on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 enable  in  1  when low, all state is frozen and outputs hold.
REQ-005 st_valid_in / st_addr_in / st_data_in / st_byte_in  in  1/XLEN/XLEN/1  executed store to allocate; byte store when st_byte_in=1, with data in [7:0].
REQ-006 full_out  out  1  cnt==NUM_ENTRIES; the memory stage stalls the store.
REQ-007 commit_in  in  1  the reorder buffer retired its head store (commit_out & commit_mem_rw_out).
REQ-008 flush_in  in  1  exception or redirect; discard every uncommitted entry.
REQ-009 dc_req_out / dc_addr_out / dc_data_out / dc_byte_out  out  1/XLEN/XLEN/1  dcache write request.
REQ-010 dc_ack_in  in  1  dcache accepted the write this cycle.
REQ-011 ld_addr_in / ld_byte_in  in  XLEN/1  load lookup for forwarding.
REQ-012 fwd_hit_out / fwd_data_out / fwd_conflict_out  out  1/XLEN/1  forward result; a conflict means the load stalls.
REQ-013 empty_out  out  1  cnt==0.

Function
REQ-014 The buffer is a circular FIFO; entry fields are valid, committed, addr, data and byte; pointers are head, tail and cmt (oldest uncommitted); cnt is $clog2(NUM_ENTRIES)+1 bits wide.
REQ-015 Allocate: st_valid_in & ~full_out writes at tail with committed=0, and tail increments modulo NUM_ENTRIES.
REQ-016 A store presented while full_out=1 is ignored, even if a pop occurs in the same cycle.
REQ-017 Commit: commit_in sets committed on the entry at cmt, and cmt increments.
REQ-018 commit_in with no uncommitted valid entry is ignored.
REQ-019 Drain FSM, states IDLE and DRAIN. IDLE->DRAIN when the head is valid and committed.
REQ-020 In DRAIN, dc_req_out=1 and dc_addr/data/byte come from the head and are held stable until dc_ack_in.
REQ-021 On dc_ack_in the head pops: head++ and cnt-- occur that cycle. The FSM stays in DRAIN if the new head is committed, else goes to IDLE.
REQ-022 dc_req_out is 0 in IDLE, so write latency is at least 1 cycle from commit.
REQ-023 Allocate and pop in the same cycle leave cnt unchanged.
REQ-024 Flush: valid is cleared on entries from cmt to tail-1, tail<=cmt, and cnt<=committed count.
REQ-025 Committed entries survive a flush and continue draining; flush is not valid mid-DRAIN on the head, since the head is committed.
REQ-026 Flush with st_valid_in in the same cycle drops the store.
REQ-027 Flush with commit_in in the same cycle applies the commit first, then flushes the remainder.
REQ-028 Forwarding is combinational and word-matched (addr[XLEN-1:2]) against all valid entries, committed or not; the youngest match (nearest tail-1) wins.
REQ-029 Word store to word load, or byte store with an equal byte offset to a byte load: hit=1 and data=the store data.
REQ-030 Word store to byte load: hit=1, data=byte lane addr[1:0] zero-extended.
REQ-031 Byte store to word load, or byte store with a different offset to a byte load: hit=0 and conflict=1.
REQ-032 No match: hit=0, conflict=0, data='0.

Reset
REQ-033 Reset clears every valid and committed bit, head/tail/cmt/cnt=0 and state=IDLE.
REQ-034 After reset, dc_req_out=0, full_out=0, empty_out=1, fwd_hit_out=0 and fwd_conflict_out=0.
REQ-035 Reset during DRAIN abandons the outstanding request; any dc_ack_in after reset is ignored.

Structure
REQ-036 XLEN, STB_NUM_ENTRIES and the stb_entry_t struct belong in brisc_pkg.
REQ-037 The forwarding search is a sub-module, stb_fwd_lookup: combinational, taking the entry array plus tail and returning hit, conflict and data.

Verification
REQ-038 Alloc word 0x100<-0xDEADBEEF, commit, ack on 2nd req cycle -> dc_req 1 cycle after commit, held 2 cycles, then empty_out=1.
REQ-039 Four allocs -> full_out=1; 5th store ignored; commit+ack one -> full_out=0 next cycle.
REQ-040 Stores 0x200<-0x11, then 0x200<-0x22; word load 0x200 -> hit, data 0x22.
REQ-041 Byte store 0x301<-0xAB: byte load 0x301 -> hit, 0xAB; word load 0x300 -> conflict=1.
REQ-042 Three stores, one committed, then flush -> cnt=1, tail=cmt; only the committed store reaches the dcache.
REQ-043 Alloc, commit and flush in one cycle with 2 uncommitted entries -> oldest committed, rest discarded, new store dropped.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared core parameters and the store-buffer entry layout.
package brisc_pkg;

    localparam int XLEN            = 32;
    localparam int STB_NUM_ENTRIES = 4;

    typedef struct packed {
        logic            valid;
        logic            committed;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic            is_byte;
    } stb_entry_t;

    typedef enum logic {
        STB_IDLE  = 1'b0,
        STB_DRAIN = 1'b1
    } stb_state_e;

endpackage

// File: rtl/stb_fwd_lookup.sv
// Combinational store-to-load forwarding search; the youngest word-matching
// valid entry decides between hit, conflict or miss.
module stb_fwd_lookup
    import brisc_pkg::*;
#(
    parameter int NUM_ENTRIES = STB_NUM_ENTRIES,
    localparam int PW = $clog2(NUM_ENTRIES)
) (
    input  stb_entry_t      entries_in [NUM_ENTRIES],
    input  logic [PW-1:0]   tail_in,
    input  logic [XLEN-1:0] ld_addr_in,
    input  logic            ld_byte_in,
    output logic            hit_out,
    output logic            conflict_out,
    output logic [XLEN-1:0] data_out
);

    logic [NUM_ENTRIES-1:0] match;
    logic [NUM_ENTRIES-1:0] unused_committed;
    logic                   found;
    stb_entry_t             sel;
    logic [PW-1:0]          idx;
    logic [XLEN-1:0]        lane;

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
            assign match[gi] = entries_in[gi].valid &&
                               (entries_in[gi].addr[XLEN-1:2] == ld_addr_in[XLEN-1:2]);
            assign unused_committed[gi] = entries_in[gi].committed;
        end
    endgenerate

    // Walk from tail (oldest slot) round to tail-1 so the youngest match overrides.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            idx = tail_in + PW'(k);
            if (match[idx]) begin
                found = 1'b1;
                sel   = entries_in[idx];
            end
        end
    end

    always_comb begin
        hit_out      = 1'b0;
        conflict_out = 1'b0;
        data_out     = '0;
        lane         = sel.data >> {ld_addr_in[1:0], 3'b000};
        if (found) begin
            if (!sel.is_byte) begin
                hit_out  = 1'b1;
                data_out = ld_byte_in ? {{(XLEN-8){1'b0}}, lane[7:0]} : sel.data;
            end else if (ld_byte_in && (sel.addr[1:0] == ld_addr_in[1:0])) begin
                hit_out  = 1'b1;
                data_out = sel.data;
            end else begin
                conflict_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: allocates executed stores, marks them committed in
// order, drains committed heads to the dcache and forwards to younger loads.
module store_buffer
    import brisc_pkg::*;
#(
    parameter int NUM_ENTRIES = STB_NUM_ENTRIES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            st_valid_in,
    input  logic [XLEN-1:0] st_addr_in,
    input  logic [XLEN-1:0] st_data_in,
    input  logic            st_byte_in,
    output logic            full_out,
    input  logic            commit_in,
    input  logic            flush_in,
    output logic            dc_req_out,
    output logic [XLEN-1:0] dc_addr_out,
    output logic [XLEN-1:0] dc_data_out,
    output logic            dc_byte_out,
    input  logic            dc_ack_in,
    input  logic [XLEN-1:0] ld_addr_in,
    input  logic            ld_byte_in,
    output logic            fwd_hit_out,
    output logic [XLEN-1:0] fwd_data_out,
    output logic            fwd_conflict_out,
    output logic            empty_out
);

    localparam int PW = $clog2(NUM_ENTRIES);
    localparam int CW = PW + 1;

    stb_entry_t    entries_q [NUM_ENTRIES];
    stb_entry_t    entries_d [NUM_ENTRIES];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] cmt_q, cmt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    stb_state_e    state_q, state_d;

    logic          alloc;
    logic          commit_fire;
    logic          pop;
    logic [CW-1:0] n_committed;
    logic [CW-1:0] n_uncommitted;

    assign full_out    = (cnt_q == CW'(NUM_ENTRIES));
    assign empty_out   = (cnt_q == '0);
    assign dc_req_out  = (state_q == STB_DRAIN);
    assign dc_addr_out = entries_q[head_q].addr;
    assign dc_data_out = entries_q[head_q].data;
    assign dc_byte_out = entries_q[head_q].is_byte;

    always_comb begin
        entries_d     = entries_q;
        head_d        = head_q;
        tail_d        = tail_q;
        cmt_d         = cmt_q;
        cnt_d         = cnt_q;
        state_d       = state_q;
        alloc         = st_valid_in && !full_out && !flush_in;
        commit_fire   = commit_in && entries_q[cmt_q].valid && !entries_q[cmt_q].committed;
        pop           = (state_q == STB_DRAIN) && dc_ack_in;
        n_committed   = '0;
        n_uncommitted = '0;

        if (enable) begin
            if (commit_fire) begin
                entries_d[cmt_q].committed = 1'b1;
                cmt_d = cmt_q + PW'(1);
            end

            // Counted after this cycle's commit so a same-cycle flush keeps it.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                n_committed = n_committed + CW'(entries_d[i].valid && entries_d[i].committed);
            end
            n_uncommitted = cnt_q - n_committed;

            if (flush_in) begin
                for (int k = 0; k < NUM_ENTRIES; k++) begin
                    if (CW'(k) < n_uncommitted) begin
                        entries_d[cmt_d + PW'(k)].valid     = 1'b0;
                        entries_d[cmt_d + PW'(k)].committed = 1'b0;
                    end
                end
                tail_d = cmt_d;
            end else if (alloc) begin
                entries_d[tail_q].valid     = 1'b1;
                entries_d[tail_q].committed = 1'b0;
                entries_d[tail_q].addr      = st_addr_in;
                entries_d[tail_q].data      = st_data_in;
                entries_d[tail_q].is_byte   = st_byte_in;
                tail_d = tail_q + PW'(1);
            end

            if (pop) begin
                entries_d[head_q].valid     = 1'b0;
                entries_d[head_q].committed = 1'b0;
                head_d = head_q + PW'(1);
            end

            if (flush_in) begin
                cnt_d = n_committed - CW'(pop);
            end else begin
                cnt_d = cnt_q + CW'(alloc) - CW'(pop);
            end

            if ((state_q == STB_DRAIN) && !dc_ack_in) begin
                state_d = STB_DRAIN;
            end else if (entries_d[head_d].valid && entries_d[head_d].committed) begin
                state_d = STB_DRAIN;
            end else begin
                state_d = STB_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            cmt_q   <= '0;
            cnt_q   <= '0;
            state_q <= STB_IDLE;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cmt_q     <= cmt_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    stb_fwd_lookup #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_fwd (
        .entries_in   (entries_q),
        .tail_in      (tail_q),
        .ld_addr_in   (ld_addr_in),
        .ld_byte_in   (ld_byte_in),
        .hit_out      (fwd_hit_out),
        .conflict_out (fwd_conflict_out),
        .data_out     (fwd_data_out)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic, all checked
// against a queue-based model of buffered stores.
module tb_store_buffer;
    import brisc_pkg::*;

    localparam int N = STB_NUM_ENTRIES;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            st_valid_in;
    logic [XLEN-1:0] st_addr_in;
    logic [XLEN-1:0] st_data_in;
    logic            st_byte_in;
    logic            full_out;
    logic            commit_in;
    logic            flush_in;
    logic            dc_req_out;
    logic [XLEN-1:0] dc_addr_out;
    logic [XLEN-1:0] dc_data_out;
    logic            dc_byte_out;
    logic            dc_ack_in;
    logic [XLEN-1:0] ld_addr_in;
    logic            ld_byte_in;
    logic            fwd_hit_out;
    logic [XLEN-1:0] fwd_data_out;
    logic            fwd_conflict_out;
    logic            empty_out;

    store_buffer #(.NUM_ENTRIES(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .st_valid_in      (st_valid_in),
        .st_addr_in       (st_addr_in),
        .st_data_in       (st_data_in),
        .st_byte_in       (st_byte_in),
        .full_out         (full_out),
        .commit_in        (commit_in),
        .flush_in         (flush_in),
        .dc_req_out       (dc_req_out),
        .dc_addr_out      (dc_addr_out),
        .dc_data_out      (dc_data_out),
        .dc_byte_out      (dc_byte_out),
        .dc_ack_in        (dc_ack_in),
        .ld_addr_in       (ld_addr_in),
        .ld_byte_in       (ld_byte_in),
        .fwd_hit_out      (fwd_hit_out),
        .fwd_data_out     (fwd_data_out),
        .fwd_conflict_out (fwd_conflict_out),
        .empty_out        (empty_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
        logic        committed;
    } m_ent_t;

    m_ent_t mq[$];
    bit     m_req;
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic void m_fwd(input logic [31:0] la, input logic lb,
                                  output logic hit, output logic conf, output logic [31:0] d);
        bit done = 0;
        hit = 0; conf = 0; d = '0;
        for (int i = mq.size() - 1; i >= 0 && !done; i--) begin
            if (mq[i].addr[31:2] == la[31:2]) begin
                done = 1;
                if (!mq[i].is_byte) begin
                    hit = 1;
                    d = lb ? ((mq[i].data >> (8 * la[1:0])) & 32'hFF) : mq[i].data;
                end else if (lb && mq[i].addr[1:0] == la[1:0]) begin
                    hit = 1;
                    d = mq[i].data;
                end else begin
                    conf = 1;
                end
            end
        end
    endfunction

    task automatic m_update();
        int sz0;
        int ci;
        sz0 = mq.size();
        if (reset) begin
            mq.delete();
            m_req = 0;
        end else if (enable) begin
            if (commit_in) begin
                ci = -1;
                for (int i = 0; i < mq.size(); i++)
                    if (ci < 0 && !mq[i].committed) ci = i;
                if (ci >= 0) mq[ci].committed = 1;
            end
            if (m_req && dc_ack_in) void'(mq.pop_front());
            if (flush_in) begin
                while (mq.size() > 0 && !mq[mq.size()-1].committed) void'(mq.pop_back());
            end else if (st_valid_in && sz0 < N) begin
                mq.push_back('{addr: st_addr_in, data: st_data_in, is_byte: st_byte_in, committed: 1'b0});
            end
            m_req = (mq.size() > 0) && mq[0].committed;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic        e_hit, e_conf;
        logic [31:0] e_data;
        #1;
        check("full", full_out, mq.size() == N);
        check("empty", empty_out, mq.size() == 0);
        check("dc_req", dc_req_out, m_req);
        if (m_req) begin
            check("dc_addr", dc_addr_out, mq[0].addr);
            check("dc_data", dc_data_out, mq[0].data);
            check("dc_byte", dc_byte_out, mq[0].is_byte);
        end
        m_fwd(ld_addr_in, ld_byte_in, e_hit, e_conf, e_data);
        check("fwd_hit", fwd_hit_out, e_hit);
        check("fwd_conflict", fwd_conflict_out, e_conf);
        check("fwd_data", fwd_data_out, e_data);
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic idle_in();
        reset = 0; enable = 1; st_valid_in = 0; st_addr_in = '0; st_data_in = '0;
        st_byte_in = 0; commit_in = 0; flush_in = 0; dc_ack_in = 0;
        ld_addr_in = '0; ld_byte_in = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b);
        idle_in();
        st_valid_in = 1; st_addr_in = a; st_data_in = d; st_byte_in = b;
        cycle();
        idle_in();
    endtask

    task automatic do_reset();
        idle_in(); reset = 1; cycle(); idle_in();
    endtask

    task automatic load_probe(input string tag, input logic [31:0] la, input logic lb,
                              input logic e_hit, input logic e_conf, input logic [31:0] e_data);
        ld_addr_in = la; ld_byte_in = lb;
        #1;
        check({tag, "_hit"}, fwd_hit_out, e_hit);
        check({tag, "_conf"}, fwd_conflict_out, e_conf);
        check({tag, "_data"}, fwd_data_out, e_data);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] bases [3];
        bases[0] = 32'h100; bases[1] = 32'h200; bases[2] = 32'h300;
        return bases[$urandom_range(2)] + ($urandom_range(3) << 2) + $urandom_range(3);
    endfunction

    initial begin
        idle_in();
        reset = 1;
        m_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_in();

        // Reset state
        check("rst_req", dc_req_out, 0);
        check("rst_full", full_out, 0);
        check("rst_empty", empty_out, 1);
        check("rst_hit", fwd_hit_out, 0);
        check("rst_conf", fwd_conflict_out, 0);

        // Single word store, commit, drain with ack on second request cycle
        store(32'h100, 32'hDEADBEEF, 0);
        commit_in = 1; cycle(); idle_in();
        check("s038_req1", dc_req_out, 1);
        check("s038_addr", dc_addr_out, 32'h100);
        check("s038_data", dc_data_out, 32'hDEADBEEF);
        cycle();
        check("s038_req2", dc_req_out, 1);
        dc_ack_in = 1; cycle(); idle_in();
        check("s038_empty", empty_out, 1);
        check("s038_req_off", dc_req_out, 0);

        // Fill, overflow store ignored, then one drain frees a slot
        do_reset();
        for (int i = 0; i < 4; i++) store(32'h400 + 4 * i, 32'h1000 + i, 0);
        check("s039_full", full_out, 1);
        store(32'h480, 32'h5555, 0);
        check("s039_still_full", full_out, 1);
        load_probe("s039_dropped", 32'h480, 0, 0, 0, 32'h0);
        commit_in = 1; cycle(); idle_in();
        dc_ack_in = 1; cycle(); idle_in();
        check("s039_not_full", full_out, 0);

        // Youngest of two stores to the same word forwards
        do_reset();
        store(32'h200, 32'h11, 0);
        store(32'h200, 32'h22, 0);
        load_probe("s040", 32'h200, 0, 1, 0, 32'h22);

        // Byte store: matching byte load hits, word load conflicts
        do_reset();
        store(32'h301, 32'hAB, 1);
        load_probe("s041_byte", 32'h301, 1, 1, 0, 32'hAB);
        load_probe("s041_word", 32'h300, 0, 0, 1, 32'h0);

        // Flush keeps only the committed store
        do_reset();
        store(32'h600, 32'hA0, 0);
        store(32'h604, 32'hA1, 0);
        store(32'h608, 32'hA2, 0);
        commit_in = 1; cycle(); idle_in();
        flush_in = 1; cycle(); idle_in();
        check("s042_empty", empty_out, 0);
        check("s042_addr", dc_addr_out, 32'h600);
        dc_ack_in = 1; cycle(); idle_in();
        check("s042_drained", empty_out, 1);
        check("s042_req", dc_req_out, 0);

        // Alloc, commit and flush together
        do_reset();
        store(32'h700, 32'hB0, 0);
        store(32'h704, 32'hB1, 0);
        st_valid_in = 1; st_addr_in = 32'h708; st_data_in = 32'hB2;
        commit_in = 1; flush_in = 1; cycle(); idle_in();
        check("s043_req", dc_req_out, 1);
        check("s043_addr", dc_addr_out, 32'h700);
        load_probe("s043_gone", 32'h708, 0, 0, 0, 32'h0);
        dc_ack_in = 1; cycle(); idle_in();
        check("s043_empty", empty_out, 1);

        // Random traffic
        do_reset();
        for (int t = 0; t < 4000; t++) begin
            reset       = ($urandom_range(299) == 0);
            enable      = ($urandom_range(9) != 0);
            st_valid_in = $urandom_range(1);
            st_byte_in  = ($urandom_range(9) < 3);
            st_addr_in  = rand_addr();
            st_data_in  = st_byte_in ? ($urandom & 32'hFF) : $urandom;
            commit_in   = ($urandom_range(9) < 3);
            flush_in    = ($urandom_range(19) == 0);
            dc_ack_in   = $urandom_range(1);
            ld_addr_in  = rand_addr();
            ld_byte_in  = $urandom_range(1);
            cycle();
        end
        idle_in();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
